// File: rtl/fetch_issue.sv
// Non-pipelined instruction fetch/issue stage: owns the PC, fetches one word,
// decodes it for the ALU, issues it once and resolves the next PC from the branch outputs.
module fetch_issue #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   input  logic        stall,
   input  logic        addrch,
   input  logic [31:0] naddr,
   output logic        issue,
   output logic [5:0]  instr,
   output logic [4:0]  rd,
   output logic [4:0]  ra,
   output logic [4:0]  rb,
   output logic [15:0] value,
   output logic        highlow,
   output logic [31:0] pc,
   output logic        illegal,
   output logic        halted
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_ISSUE   = 3'd2,
      ST_RESOLVE = 3'd3,
      ST_HALT    = 3'd4
   } state_t;

   state_t      state_r;
   state_t      state_s;
   logic [31:0] pc_r;
   logic [31:0] pc_s;
   logic [31:0] ir_r;
   logic [31:0] ir_s;
   logic        halted_r;
   logic        halted_s;
   logic        mem_req_s;
   logic        issue_s;
   logic        illegal_s;
   logic [5:0]  op_s;
   logic        op_legal_s;
   logic        op_halt_s;

   assign op_s       = ir_r[31:26];
   assign op_legal_s = (op_s < 6'd16);
   assign op_halt_s  = (op_s == 6'd63);

   // State, PC, instruction register and sticky halt flag
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r  <= ST_IDLE;
         pc_r     <= RESET_ADDR;
         ir_r     <= 32'd0;
         halted_r <= 1'b0;
      end else begin
         state_r  <= state_s;
         pc_r     <= pc_s;
         ir_r     <= ir_s;
         halted_r <= halted_s;
      end
   end

   // Next-state, next-PC and strobe decode
   always_comb begin
      state_s   = state_r;
      pc_s      = pc_r;
      ir_s      = ir_r;
      halted_s  = halted_r;
      mem_req_s = 1'b0;
      issue_s   = 1'b0;
      illegal_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            state_s = ST_FETCH;
         end
         ST_FETCH: begin
            mem_req_s = 1'b1;
            if (mem_ready) begin
               ir_s    = mem_rdata;
               state_s = ST_ISSUE;
            end else begin
               state_s = ST_FETCH;
            end
         end
         ST_ISSUE: begin
            if (op_legal_s) begin
               if (!stall) begin
                  issue_s = 1'b1;
                  state_s = ST_RESOLVE;
               end else begin
                  state_s = ST_ISSUE;
               end
            end else if (op_halt_s) begin
               halted_s = 1'b1;
               state_s  = ST_HALT;
            end else begin
               illegal_s = 1'b1;
               state_s   = ST_RESOLVE;
            end
         end
         ST_RESOLVE: begin
            // An illegal opcode never reached the ALU, so its branch output is not trusted
            if (addrch && op_legal_s) begin
               pc_s = naddr & 32'hFFFF_FFFC;
            end else begin
               pc_s = pc_r + 32'd4;
            end
            state_s = ST_FETCH;
         end
         ST_HALT: begin
            state_s = ST_HALT;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   assign mem_req  = mem_req_s;
   assign mem_addr = pc_r;
   assign pc       = pc_r;
   assign issue    = issue_s;
   assign illegal  = illegal_s;
   assign halted   = halted_r;
   assign instr    = ir_r[31:26];
   assign rd       = ir_r[25:21];
   assign ra       = ir_r[20:16];
   assign rb       = ir_r[15:11];
   assign value    = ir_r[15:0];
   assign highlow  = (op_s == 6'd6);

endmodule

// File: tb/tb_fetch_issue.sv
// Randomized scoreboard bench for fetch_issue: the stimulus side acts as memory and
// ALU, predicts each instruction's outcome, and a negedge monitor checks the DUT.
module tb_fetch_issue;

   localparam logic [31:0] RST = 32'hFFFF_FFFC;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = 32'd0;
   logic        stall = 1'b0;
   logic        addrch = 1'b0;
   logic [31:0] naddr = 32'd0;
   logic        issue;
   logic [5:0]  instr;
   logic [4:0]  rd;
   logic [4:0]  ra;
   logic [4:0]  rb;
   logic [15:0] value;
   logic        highlow;
   logic [31:0] pc;
   logic        illegal;
   logic        halted;

   fetch_issue #(.RESET_ADDR(RST)) dut (
      .clock(clock), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall(stall),
      .addrch(addrch), .naddr(naddr), .issue(issue), .instr(instr),
      .rd(rd), .ra(ra), .rb(rb), .value(value), .highlow(highlow),
      .pc(pc), .illegal(illegal), .halted(halted)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   // expected issue record: decoded fields followed by the PC of the instruction
   logic [69:0]  iss_q[$];
   logic [31:0]  ill_q[$];
   logic [31:0]  addr_q[$];
   logic [31:0]  model_pc;

   task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string nm);
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL %s (t=%0t)", nm, $time);
   endtask

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   function automatic logic [37:0] decode(input logic [31:0] w);
      return {w[31:26], w[25:21], w[20:16], w[15:11], w[15:0], (w[31:26] == 6'd6)};
   endfunction

   logic        prev_req = 1'b0;
   logic        prev_issue = 1'b0;
   logic [31:0] prev_addr = 32'd0;

   // Monitor: pops the scoreboard whenever the DUT presents an issue, illegal or fetch
   always @(negedge clock) begin
      if (reset) begin
         prev_req   <= 1'b0;
         prev_issue <= 1'b0;
      end else begin
         if (issue) begin
            chk("issue_not_consecutive", 70'(prev_issue), 70'(0));
            if (iss_q.size() == 0) fail_now("issue_unexpected");
            else chk("issue_fields", {instr, rd, ra, rb, value, highlow, pc}, iss_q.pop_front());
         end
         if (illegal) begin
            if (ill_q.size() == 0) fail_now("illegal_unexpected");
            else chk("illegal_pc", 70'(pc), 70'(ill_q.pop_front()));
         end
         if (mem_req && prev_req) chk("fetch_addr_stable", 70'(mem_addr), 70'(prev_addr));
         if (mem_req && mem_ready) begin
            if (addr_q.size() == 0) fail_now("fetch_unexpected");
            else chk("fetch_addr", 70'(mem_addr), 70'(addr_q.pop_front()));
         end
         prev_req   <= mem_req;
         prev_addr  <= mem_addr;
         prev_issue <= issue;
      end
   end

   task automatic clear_model;
      iss_q.delete();
      ill_q.delete();
      addr_q.delete();
      addr_q.push_back(RST);
      model_pc = RST;
   endtask

   task automatic do_reset;
      reset = 1'b1; mem_ready = 1'b0; stall = 1'b0; addrch = 1'b0;
      step;
      step;
      clear_model();
      chk("rst_pc", 70'(pc), 70'(RST));
      chk("rst_strobes", 70'({mem_req, issue, illegal, halted}), 70'(0));
      chk("rst_fields", 70'({instr, rd, ra, rb, value, highlow}), 70'(0));
      reset = 1'b0;
      chk("idle_no_req", 70'(mem_req), 70'(0));
      step;
      chk("first_req", 70'({mem_req, mem_addr}), 70'({1'b1, RST}));
   endtask

   // One instruction as memory + ALU: wait cycles, handshake, stall cycles, branch choice
   task automatic do_instr(input logic [31:0] w, input int waitc, input int stallc,
                           input logic br, input logic [31:0] tgt);
      int          t0;
      int          k;
      logic [5:0]  op;
      logic [31:0] nxt;
      op = w[31:26];
      k = 0;
      while (!mem_req && k < 30) begin step; k++; end
      if (!mem_req) begin fail_now("fetch_timeout"); return; end
      t0 = cyc;
      for (int i = 0; i < waitc; i++) begin
         mem_ready = 1'b0; addrch = 1'($urandom); naddr = $urandom;
         step;
      end
      mem_ready = 1'b1; mem_rdata = w; addrch = br; naddr = tgt;
      if (op < 6'd16) iss_q.push_back({decode(w), model_pc});
      else if (op != 6'd63) ill_q.push_back(model_pc);
      if (op < 6'd16 && br) nxt = (tgt >> 2) << 2;
      else nxt = model_pc + 32'd4;
      if (op != 6'd63) begin
         addr_q.push_back(nxt);
         model_pc = nxt;
      end
      step;
      mem_ready = 1'b0; mem_rdata = $urandom;
      if (op == 6'd63) begin
         step;
         chk("halted_set", 70'(halted), 70'(1));
         for (int i = 0; i < 10; i++) begin
            chk("halt_quiet", 70'({mem_req, issue, illegal, halted}), 70'(4'b0001));
            step;
         end
         return;
      end
      for (int i = 0; i < stallc; i++) begin
         stall = 1'b1;
         chk("fields_hold", 70'({instr, rd, ra, rb, value, highlow}), 70'(decode(w)));
         step;
      end
      stall = 1'b0;
      k = 0;
      while (!mem_req && k < 30) begin
         chk("fields_hold", 70'({instr, rd, ra, rb, value, highlow}), 70'(decode(w)));
         step;
         k++;
      end
      if (!mem_req) fail_now("next_fetch_timeout");
      else if (op < 6'd16) chk("instr_cycles", 70'(cyc - t0), 70'(waitc + stallc + 3));
      else chk("illegal_cycles", 70'(cyc - t0), 70'(waitc + 3));
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] r;
      logic [5:0]  op;
      r = $urandom;
      if ($urandom_range(0, 9) < 7) op = 6'($urandom_range(0, 15));
      else op = 6'($urandom_range(16, 62));
      return {op, r[25:0]};
   endfunction

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      do_reset();
      // sequential: FFFFFFFC wraps to 0, then 0, 4, 8
      do_instr(32'h0000_0000, 0, 0, 1'b0, 32'd0);
      do_instr(32'h0001_0000, 0, 0, 1'b0, 32'd0);
      do_instr(32'h0002_0001, 0, 0, 1'b0, 32'd0);
      do_instr(32'h03FF_FFFF, 0, 0, 1'b0, 32'd0);
      // decode at 12, then branch from 0x10 to 0x103 -> 0x100
      do_instr(32'h1862_A5A5, 0, 0, 1'b0, 32'd0);
      do_instr(32'h0462_0004, 0, 0, 1'b1, 32'h0000_0103);
      // wait 2 + stall 3 => 8 cycles
      do_instr(32'h0842_1234, 2, 3, 1'b0, 32'd0);
      // illegal opcode 20 with a taken branch that must be ignored
      do_instr({6'd20, 26'h155_5555}, 0, 1, 1'b1, 32'h0000_4000);
      for (int n = 0; n < 40; n++) begin
         do_instr(rand_word(), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                  1'($urandom), $urandom);
      end
      // halt, then reset restarts at RESET_ADDR
      do_instr({6'd63, 26'h0}, 0, 0, 1'b0, 32'd0);
      do_reset();
      chk("halted_cleared", 70'(halted), 70'(0));
      do_instr(32'h0400_0001, 1, 0, 1'b0, 32'd0);
      // reset mid-fetch with a late memory response
      if (!mem_req) fail_now("midfetch_no_req");
      reset = 1'b1;
      step;
      reset = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h0C21_FFFF;
      clear_model();
      chk("midfetch_state", 70'({mem_req, pc, instr}), 70'({1'b0, RST, 6'd0}));
      step;
      mem_ready = 1'b0;
      chk("midfetch_restart", 70'({mem_req, mem_addr, instr}), 70'({1'b1, RST, 6'd0}));
      do_instr(32'h1862_A5A5, 0, 1, 1'b0, 32'd0);
      step;
      step;
      chk("issue_q_drained", 70'(iss_q.size()), 70'(0));
      chk("illegal_q_drained", 70'(ill_q.size()), 70'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_issue.md
# fetch_issue

Instruction fetch and issue stage sitting directly upstream of the ALU. It owns the program counter and fetches one 32-bit instruction word at a time from instruction memory over a req/ready handshake. It decodes the word into the ALU's opcode, register-select and immediate fields, issues it for one cycle, then consumes the ALU's branch outputs (`addrch`, `naddr`) to select the next PC. The stage is strictly non-pipelined: one instruction in flight.

## Interface
Parameters:
- `RESET_ADDR`, default 32'h0000_0000: PC value after reset. Bits [1:0] must be 0.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `mem_req`  out  1: fetch request, high in FETCH.
- `mem_addr`  out  32: fetch address, equal to `pc`.
- `mem_ready`  in  1: memory has valid data this cycle. Ignored outside FETCH.
- `mem_rdata`  in  32: instruction word, sampled when `mem_req & mem_ready`.
- `stall`  in  1: downstream hold. Delays issue.
- `addrch`  in  1: ALU branch-taken, sampled in RESOLVE.
- `naddr`  in  32: ALU branch target, sampled in RESOLVE.
- `issue`  out  1: one-cycle strobe; decoded fields are valid for the ALU.
- `instr`  out  6: opcode, IR[31:26].
- `rd`, `ra`, `rb`  out  5 each: IR[25:21], IR[20:16], IR[15:11].
- `value`  out  16: immediate, IR[15:0].
- `highlow`  out  1: 1 when opcode == 6, else 0.
- `pc`  out  32: current program counter.
- `illegal`  out  1: one-cycle pulse on an undefined opcode.
- `halted`  out  1: sticky, set by the HALT opcode.

## Operation
- States: IDLE, FETCH, ISSUE, RESOLVE, HALT.
- IDLE: reset state. Always goes to FETCH on the next cycle.
- FETCH:
  - `mem_req`=1 and `mem_addr`=`pc`, held stable until `mem_ready`.
  - On `mem_ready`: IR <= `mem_rdata`, then go to ISSUE.
- ISSUE:
  - Opcode 0–15: `issue` = !`stall`. Go to RESOLVE when !`stall`; otherwise stay in ISSUE.
  - Opcode 63: no issue. Set `halted`, go to HALT.
  - Opcode 16–62: no issue. Pulse `illegal` for one cycle, go to RESOLVE with the branch forced not-taken.
- RESOLVE (exactly one cycle):
  - If `addrch`=1: `pc` <= {`naddr`[31:2], 2'b00}.
  - Otherwise: `pc` <= `pc` + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
  - Then go to FETCH.
- HALT: absorbing state. All strobes stay 0; only `reset` exits.
- IR and all decoded fields hold from the IR load until the next IR load. They are stable through ISSUE and RESOLVE, so the ALU sees constant inputs while its result is taken.
- `addrch`/`naddr` are ignored outside RESOLVE.

## Timing
- Reset values:
  - State: IDLE.
  - `pc` and `mem_addr`: `RESET_ADDR`.
  - IR: 0, so `instr`, `rd`, `ra`, `rb`, `value`, `highlow` are all 0.
  - `mem_req`, `issue`, `illegal`, `halted`: 0.
- `reset` high at any edge, including mid-fetch or while stalled:
  - Everything returns to reset values on that edge.
  - `mem_req` is 0 on the following cycle; a pending memory response is dropped.
- Output timing: `mem_req`, `issue`, `illegal` are combinational from state and registered flags. `pc` and the decoded fields are registered.
- Zero-wait memory (`mem_ready` high in the first FETCH cycle), no stall: 3 cycles per instruction (FETCH, ISSUE, RESOLVE).
- First `mem_req` is high on the 2nd cycle after `reset` deasserts (the IDLE cycle comes first).
- Each wait cycle on `mem_ready` or each cycle of `stall` adds exactly one cycle.
- `stall` and `mem_ready` are never relevant in the same state, so they cannot conflict.
- `issue` is never high for two consecutive cycles.

## Test plan
- Sequential fetch: memory returns opcode 0 at addresses 0, 4, 8 with `mem_ready` tied high and `addrch`=0. Required: `issue` pulses every 3rd cycle; `mem_addr` goes 0, 4, 8, 12.
- Branch: in RESOLVE of the instruction at 0x10, drive `addrch`=1 and `naddr`=0x0000_0103. Required: next `mem_addr`=0x0000_0100.
- Wait and stall: `mem_ready` low for 2 cycles, then `stall` high for 3 cycles in ISSUE. Required: `mem_req`/`mem_addr` held stable, `issue` delayed, total 8 cycles for that instruction, fields unchanged throughout.
- Decode: word 0x1862_A5A5 (opcode 6). Required: `instr`=6, `rd`=3, `ra`=2, `rb`=20, `value`=0xA5A5, `highlow`=1. Also `RESET_ADDR`=32'hFFFF_FFFC, no branch: next fetch at 0.
- Illegal and halt: opcode 20 gives `illegal` for one cycle, no `issue`, and `pc`+4. Opcode 63 gives `halted`=1 with `mem_req` 0 forever. Assert `reset`: `halted` clears and fetch restarts at `RESET_ADDR`.
- Reset mid-fetch: `reset` asserted while `mem_req`=1. Required: next cycle `mem_req`=0, `pc`=`RESET_ADDR`; a late `mem_ready` is ignored.
